// File: rtl/sa_fill_controller.sv
// Set-associative cache line fill controller: optional dirty-victim writeback,
// line fill from backing memory, tag update, then a one-cycle completion pulse.
module sa_fill_controller #(
  parameter int TAG_BITS   = 18,
  parameter int INDEX_BITS = 8,
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 16,
  parameter int DATA_WIDTH = 32,
  localparam int WAY_BITS  = $clog2(WAYS),
  localparam int WORD_BITS = $clog2(LINE_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_miss_req,
  input  logic [TAG_BITS-1:0]   i_miss_tag,
  input  logic [INDEX_BITS-1:0] i_miss_index,
  input  logic [WAY_BITS-1:0]   i_victim_way,
  input  logic                  i_victim_dirty,
  input  logic [TAG_BITS-1:0]   i_victim_tag,
  output logic [WAY_BITS-1:0]   o_arr_way,
  output logic [INDEX_BITS-1:0] o_arr_index,
  output logic [WORD_BITS-1:0]  o_arr_word,
  input  logic [DATA_WIDTH-1:0] i_arr_rdata,
  output logic                  o_arr_we,
  output logic [DATA_WIDTH-1:0] o_arr_wdata,
  output logic                  o_tag_we,
  output logic [TAG_BITS-1:0]   o_tag_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [31:0]           o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_miss_ack,
  output logic                  o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WB     = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [WORD_BITS-1:0]  r_cnt;
  logic [TAG_BITS-1:0]   r_tag;
  logic [TAG_BITS-1:0]   r_vtag;
  logic [INDEX_BITS-1:0] r_index;
  logic [WAY_BITS-1:0]   r_way;

  logic w_in_wb;
  logic w_in_fill;
  logic w_beat;
  logic w_last_beat;
  logic w_xfer_entry;

  assign w_in_wb      = (r_state == S_WB);
  assign w_in_fill    = (r_state == S_FILL);
  assign w_beat       = (w_in_wb | w_in_fill) & i_mem_ready;
  assign w_last_beat  = w_beat & (r_cnt == LAST_WORD);
  assign w_xfer_entry = (w_next != r_state) & ((w_next == S_WB) | (w_next == S_FILL));

  // Next-state selection; WB and FILL only advance on the final accepted beat.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_miss_req) begin
          w_next = i_victim_dirty ? S_WB : S_FILL;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        if (w_last_beat) begin
          w_next = S_FILL;
        end else begin
          w_next = S_WB;
        end
      end
      S_FILL: begin
        if (w_last_beat) begin
          w_next = S_UPDATE;
        end else begin
          w_next = S_FILL;
        end
      end
      S_UPDATE: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register and miss capture; request inputs are only looked at in IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_tag   <= {TAG_BITS{1'b0}};
      r_vtag  <= {TAG_BITS{1'b0}};
      r_index <= {INDEX_BITS{1'b0}};
      r_way   <= {WAY_BITS{1'b0}};
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && i_miss_req) begin
        r_tag   <= i_miss_tag;
        r_vtag  <= i_victim_tag;
        r_index <= i_miss_index;
        r_way   <= i_victim_way;
      end
    end
  end

  // Word counter: restarts on entry to each transfer, advances per accepted beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {WORD_BITS{1'b0}};
    end else if (w_xfer_entry) begin
      r_cnt <= {WORD_BITS{1'b0}};
    end else if (w_beat) begin
      r_cnt <= r_cnt + WORD_BITS'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_arr_way   = r_way;
  assign o_arr_index = r_index;
  assign o_arr_word  = r_cnt;
  assign o_arr_we    = w_in_fill & i_mem_ready;
  assign o_arr_wdata = w_in_fill ? i_mem_rdata : {DATA_WIDTH{1'b0}};
  assign o_tag_we    = (r_state == S_UPDATE);
  assign o_tag_wdata = r_tag;
  assign o_mem_req   = w_in_wb | w_in_fill;
  assign o_mem_we    = w_in_wb;
  assign o_mem_wdata = w_in_wb ? i_arr_rdata : {DATA_WIDTH{1'b0}};
  assign o_miss_ack  = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);

  // Byte address of the current line word; the tag source depends on direction.
  always_comb begin
    o_mem_addr = 32'd0;
    if (w_in_wb) begin
      o_mem_addr = 32'({r_vtag, r_index, r_cnt, 2'b00});
    end else if (w_in_fill) begin
      o_mem_addr = 32'({r_tag, r_index, r_cnt, 2'b00});
    end else begin
      o_mem_addr = 32'd0;
    end
  end

endmodule
